// File: rtl/simple_mips_data_mem_responder.sv
// Word-indexed data memory behind the CPU data port: zero-wait-state writes,
// reads with a fixed RD_LATENCY wait-state sequence (IDLE -> WAIT -> RESP).
module simple_mips_data_mem_responder #(
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_ctrl,
  input  logic        memwrite_ctrl,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_wrdata,
  output logic [31:0] data_mem_rd_data,
  output logic        mem_ready,
  output logic        mem_rd_valid,
  output logic        addr_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic        err_reg, err_next;
  logic        wr_en, rd_load;
  logic [31:0] rd_addr;
  logic        wr_in_range, rd_in_range;
  logic [31:0] mem [DEPTH];

  // Full 32-bit compare: upper address bits must never alias into the array.
  assign wr_in_range = data_mem_addr < DEPTH_W;
  // With RD_LATENCY==1 the array is read on the accept edge, before addr_reg is loaded.
  assign rd_addr     = (state_reg == IDLE) ? data_mem_addr : addr_reg;
  assign rd_in_range = rd_addr < DEPTH_W;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    rd_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memwrite_ctrl) begin
          wr_en    = wr_in_range;
          err_next = !wr_in_range;
        end else if (memread_ctrl) begin
          addr_next = data_mem_addr;
          if (RD_LATENCY == 1) begin
            state_next = RESP;
            rd_load    = 1'b1;
            err_next   = !rd_in_range;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          rd_load    = 1'b1;
          err_next   = !rd_in_range;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data_next = rd_data_reg;
    if (rd_load) begin
      rd_data_next = rd_in_range ? mem[rd_addr[AW-1:0]] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      addr_reg    <= 32'd0;
      rd_data_reg <= 32'd0;
      err_reg     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      rd_data_reg <= rd_data_next;
      err_reg     <= err_next;
      if (wr_en) begin
        mem[data_mem_addr[AW-1:0]] <= data_mem_wrdata;
      end
    end
  end

  assign mem_ready        = (state_reg == IDLE);
  assign mem_rd_valid     = (state_reg == RESP);
  assign addr_err         = err_reg;
  assign data_mem_rd_data = rd_data_reg;

endmodule

// File: tb/tb_simple_mips_data_mem_responder.sv
// Scoreboarded bench: a RD_LATENCY=2 instance with a reference word model,
// plus a RD_LATENCY=1 instance exercised with back-to-back reads.
module tb_simple_mips_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_ctrl, memwrite_ctrl;
  logic [31:0] data_mem_addr, data_mem_wrdata;
  logic [31:0] data_mem_rd_data;
  logic        mem_ready, mem_rd_valid, addr_err;

  logic        rd1;
  logic [31:0] rd_data1;
  logic        ready1, valid1, err1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simple_mips_data_mem_responder #(.DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .memread_ctrl(memread_ctrl), .memwrite_ctrl(memwrite_ctrl),
    .data_mem_addr(data_mem_addr), .data_mem_wrdata(data_mem_wrdata),
    .data_mem_rd_data(data_mem_rd_data),
    .mem_ready(mem_ready), .mem_rd_valid(mem_rd_valid), .addr_err(addr_err)
  );

  simple_mips_data_mem_responder #(.DEPTH(DEPTH), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .memread_ctrl(rd1), .memwrite_ctrl(memwrite_ctrl),
    .data_mem_addr(data_mem_addr), .data_mem_wrdata(data_mem_wrdata),
    .data_mem_rd_data(rd_data1),
    .mem_ready(ready1), .mem_rd_valid(valid1), .addr_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a < DEPTH) ? model[a[4:0]] : 32'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic oor;
    oor = (a >= DEPTH);
    data_mem_addr   = a;
    data_mem_wrdata = d;
    memwrite_ctrl   = 1'b1;
    @(posedge clk); #1;
    memwrite_ctrl = 1'b0;
    check("wr_err", {31'd0, addr_err}, {31'd0, oor});
    check("wr_ready", {31'd0, mem_ready}, 32'd1);
    if (!oor) model[a[4:0]] = d;
    $display("WR  addr=%h data=%h err=%0b", a, d, addr_err);
    if (oor) begin
      @(posedge clk); #1;
      check("wr_err_pulse", {31'd0, addr_err}, 32'd0);
    end
  endtask

  // Holds memread_ctrl until rd_valid; optionally drives a stray write during WAIT.
  task automatic do_read(input logic [31:0] a, input bit wr_in_wait);
    int  low;
    bit  seen;
    exp_t e;
    low  = 0;
    seen = 0;
    e.data = model_rd(a);
    e.err  = (a >= DEPTH);
    e.acc  = cyc;
    sb_q.push_back(e);
    data_mem_addr = a;
    memread_ctrl  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!mem_ready) low++;
      if (mem_rd_valid) begin
        seen = 1;
        break;
      end
      if (i == 0 && wr_in_wait) begin
        memwrite_ctrl   = 1'b1;
        data_mem_addr   = a;
        data_mem_wrdata = 32'h1234_5678;
      end
    end
    memread_ctrl  = 1'b0;
    memwrite_ctrl = 1'b0;
    check("rd_seen", {31'd0, seen}, 32'd1);
    check("rd_stall_cycles", 32'(low), 32'(LAT));
    $display("RD  addr=%h data=%h err=%0b stall=%0d", a, data_mem_rd_data, addr_err, low);
    @(posedge clk); #1;
    check("rd_back_idle", {31'd0, mem_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (mem_rd_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_data", data_mem_rd_data, mon_e.data);
        check("rd_addr_err", {31'd0, addr_err}, {31'd0, mon_e.err});
        check("rd_latency", 32'(cyc - mon_e.acc), 32'(LAT));
      end
    end
  end

  initial begin
    rst = 1'b1; memread_ctrl = 1'b0; memwrite_ctrl = 1'b0; rd1 = 1'b0;
    data_mem_addr = 32'd0; data_mem_wrdata = 32'd0;
    repeat (2) @(posedge clk);
    do_reset();

    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_valid", {31'd0, mem_rd_valid}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    check("rst_data", data_mem_rd_data, 32'd0);
    do_read(32'd5, 0);

    do_write(32'd0, 32'd1);
    do_write(32'd1, 32'd5);
    do_write(32'd2, 32'd5);
    for (int i = 0; i < 3; i++) do_read(32'(i), 0);

    // Read-after-write on the very next edge, then a stray write during WAIT.
    do_write(32'd3, 32'hDEAD_BEEF);
    do_read(32'd3, 1);
    do_read(32'd3, 0);

    do_read(32'd32, 0);
    do_write(32'h8000_0000, 32'h5555_5555);
    do_write(32'hFFFF_FFE0, 32'h6666_6666);
    do_read(32'd0, 0);
    do_read(32'hFFFF_FFFF, 0);

    data_mem_addr = 32'd7; data_mem_wrdata = 32'd9;
    memread_ctrl = 1'b1; memwrite_ctrl = 1'b1;
    @(posedge clk); #1;
    memread_ctrl = 1'b0; memwrite_ctrl = 1'b0;
    model[7] = 32'd9;
    check("both_ready", {31'd0, mem_ready}, 32'd1);
    check("both_valid", {31'd0, mem_rd_valid}, 32'd0);
    $display("RW  addr=%h data=%h ready=%0b", 32'd7, 32'd9, mem_ready);
    @(posedge clk); #1;
    check("both_no_read", {31'd0, mem_ready}, 32'd1);
    do_read(32'd7, 0);

    data_mem_addr = 32'd4; memread_ctrl = 1'b1;
    @(posedge clk); #1;
    memread_ctrl = 1'b0;
    check("wait_entered", {31'd0, mem_ready}, 32'd0);
    do_reset();
    check("rst_mid_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, mem_rd_valid}, 32'd0);
    $display("RST during WAIT ready=%0b valid=%0b", mem_ready, mem_rd_valid);
    repeat (3) @(posedge clk);
    #1;
    do_read(32'd0, 0);
    do_read(32'd7, 0);

    do_reset();
    do_write(32'd10, 32'h11);
    do_write(32'd11, 32'h22);
    do_write(32'd12, 32'h33);
    rd1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_mem_addr = 32'(10 + k);
      @(posedge clk); #1;
      check("l1_valid", {31'd0, valid1}, 32'd1);
      check("l1_busy", {31'd0, ready1}, 32'd0);
      check("l1_data", rd_data1, model_rd(32'(10 + k)));
      $display("RD1 addr=%h data=%h", 32'(10 + k), rd_data1);
      @(posedge clk); #1;
      check("l1_idle", {31'd0, ready1}, 32'd1);
      check("l1_valid_off", {31'd0, valid1}, 32'd0);
    end
    rd1 = 1'b0;

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
